// File: rtl/seq_step_display.sv
// seq_step_display: parametrised step sequencer for one active-low 7-segment digit.
// Steps VALUE up or down between 0 and MAX_VAL once every DIV = CLK_HZ/STEP_HZ cycles,
// with wrap or stop-at-end behaviour, pause, and a clamped parallel load.
// Optional feature macro: SEQ_STEP_BLINK_EN blinks the digit while paused or holding.
module seq_step_display #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 1,
    parameter int MAX_VAL = 5,
    parameter int WRAP    = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       EN,
    input  logic       DIR,
    input  logic       LOAD,
    input  logic [3:0] LOAD_VAL,
    output logic [3:0] VALUE,
    output logic [6:0] HEX0,
    output logic       TICK,
    output logic       DONE
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam logic [3:0]       TOP      = 4'(MAX_VAL);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       load_clamped;
    logic             at_end;
    logic [6:0]       digit;

    // Loads above the range are pinned to the top; the end test depends on direction.
    assign load_clamped = (LOAD_VAL > TOP) ? TOP : LOAD_VAL;
    assign at_end       = DIR ? (VALUE == TOP) : (VALUE == 4'd0);

    // Sequencer: reset, then load, then the divider/step in RUN, then EN-driven state moves.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            VALUE   <= DIR ? 4'd0 : TOP;
            div_cnt <= '0;
            TICK    <= 1'b0;
            DONE    <= 1'b0;
            state   <= EN ? RUN : PAUSE;
        end else if (LOAD) begin
            VALUE   <= load_clamped;
            div_cnt <= '0;
            TICK    <= 1'b0;
            DONE    <= 1'b0;
            state   <= EN ? RUN : PAUSE;
        end else begin
            TICK <= 1'b0;
            if (WRAP != 0) begin
                DONE <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (!EN) begin
                        state <= PAUSE;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        TICK    <= 1'b1;
                        if (at_end) begin
                            DONE <= 1'b1;
                            if (WRAP != 0) begin
                                VALUE <= DIR ? 4'd0 : TOP;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            VALUE <= DIR ? VALUE + 4'd1 : VALUE - 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (EN) begin
                        state <= RUN;
                    end
                end
                HOLD: begin
                    state <= HOLD;
                end
                default: begin
                    state <= PAUSE;
                end
            endcase
        end
    end

    // Active-low hex decode of the current value, segment order {g,f,e,d,c,b,a}.
    always_comb begin
        digit = 7'b1111111;
        case (VALUE)
            4'h0: digit = 7'b1000000;
            4'h1: digit = 7'b1111001;
            4'h2: digit = 7'b0100100;
            4'h3: digit = 7'b0110000;
            4'h4: digit = 7'b0011001;
            4'h5: digit = 7'b0010010;
            4'h6: digit = 7'b0000010;
            4'h7: digit = 7'b1111000;
            4'h8: digit = 7'b0000000;
            4'h9: digit = 7'b0010000;
            4'hA: digit = 7'b0001000;
            4'hB: digit = 7'b0000011;
            4'hC: digit = 7'b1000110;
            4'hD: digit = 7'b0100001;
            4'hE: digit = 7'b0000110;
            4'hF: digit = 7'b0001110;
            default: digit = 7'b1111111;
        endcase
    end

`ifdef SEQ_STEP_BLINK_EN
    localparam int HALF    = DIV / 2;
    localparam int BLINK_W = $clog2(HALF + 1);
    localparam logic [BLINK_W-1:0] HALF_LAST = BLINK_W'(HALF - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blank;

    // Blink timer: held clear while running so the digit shows first after pausing.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || LOAD || state == RUN) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else if (blink_cnt == HALF_LAST) begin
            blink_cnt <= '0;
            blank     <= ~blank;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign HEX0 = (blank && state != RUN) ? 7'h7F : digit;
`else
    assign HEX0 = digit;
`endif

endmodule

// File: tb/tb_seq_step_display.sv
// tb_seq_step_display: directed vector table plus randomized run against a reference model.
// Two instances share the stimulus: one wrapping (WRAP=1), one stopping at the end (WRAP=0).
module tb_seq_step_display;

    localparam int CLK_HZ  = 10;
    localparam int STEP_HZ = 1;
    localparam int MAX_VAL = 5;
    localparam int DIV     = CLK_HZ / STEP_HZ;

    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_HOLD  = 2;

    logic       clock = 1'b0;
    logic       reset, en, dir, load;
    logic [3:0] load_val;
    logic [3:0] value_w, value_h;
    logic [6:0] hex_w, hex_h;
    logic       tick_w, tick_h, done_w, done_h;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tab [16];

    int m_value [2];
    int m_phase [2];
    int m_mode  [2];
    int m_tick  [2];
    int m_done  [2];

    typedef struct {
        int reset;
        int en;
        int dir;
        int load;
        int lv;
        int cycles;
        int wv;
        int tk;
        int wd;
        int hv;
        int hd;
    } vec_t;

    vec_t vecs [29];

    always #5 clock = ~clock;

    seq_step_display #(
        .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .MAX_VAL(MAX_VAL), .WRAP(1)
    ) dut_wrap (
        .CLOCK_50(clock), .RESET(reset), .EN(en), .DIR(dir), .LOAD(load),
        .LOAD_VAL(load_val), .VALUE(value_w), .HEX0(hex_w), .TICK(tick_w), .DONE(done_w)
    );

    seq_step_display #(
        .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .MAX_VAL(MAX_VAL), .WRAP(0)
    ) dut_hold (
        .CLOCK_50(clock), .RESET(reset), .EN(en), .DIR(dir), .LOAD(load),
        .LOAD_VAL(load_val), .VALUE(value_h), .HEX0(hex_h), .TICK(tick_h), .DONE(done_h)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour: phase counts completed running cycles since the last restart.
    task automatic modelStep(input int k, input bit wraps);
        int nxt;
        if (reset) begin
            m_value[k] = dir ? 0 : MAX_VAL;
            m_phase[k] = 0;
            m_tick[k]  = 0;
            m_done[k]  = 0;
            m_mode[k]  = en ? M_RUN : M_PAUSE;
        end else if (load) begin
            m_value[k] = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
            m_phase[k] = 0;
            m_tick[k]  = 0;
            m_done[k]  = 0;
            m_mode[k]  = en ? M_RUN : M_PAUSE;
        end else begin
            m_tick[k] = 0;
            if (wraps) m_done[k] = 0;
            if (m_mode[k] == M_RUN) begin
                if (!en) begin
                    m_mode[k] = M_PAUSE;
                end else begin
                    m_phase[k] = m_phase[k] + 1;
                    if (m_phase[k] == DIV) begin
                        m_phase[k] = 0;
                        m_tick[k]  = 1;
                        nxt = m_value[k] + (dir ? 1 : -1);
                        if (nxt < 0 || nxt > MAX_VAL) begin
                            m_done[k] = 1;
                            if (wraps) m_value[k] = dir ? 0 : MAX_VAL;
                            else       m_mode[k]  = M_HOLD;
                        end else begin
                            m_value[k] = nxt;
                        end
                    end
                end
            end else if (m_mode[k] == M_PAUSE) begin
                if (en) m_mode[k] = M_RUN;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit d, input bit l,
                                 input logic [3:0] lv);
        reset    = r;
        en       = e;
        dir      = d;
        load     = l;
        load_val = lv;
        @(posedge clock);
        modelStep(0, 1'b1);
        modelStep(1, 1'b0);
        #1;
    endtask

    task automatic checkOutput();
        check("model value_w", int'(value_w), m_value[0]);
        check("model hex_w",   int'(hex_w),   int'(seg_tab[m_value[0]]));
        check("model tick_w",  int'(tick_w),  m_tick[0]);
        check("model done_w",  int'(done_w),  m_done[0]);
        check("model value_h", int'(value_h), m_value[1]);
        check("model hex_h",   int'(hex_h),   int'(seg_tab[m_value[1]]));
        check("model tick_h",  int'(tick_h),  m_tick[1]);
        check("model done_h",  int'(done_h),  m_done[1]);
    endtask

    initial begin
        bit r_dir;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        //          rst en dir ld lv cyc  wv tk wd hv hd
        vecs[0]  = '{1, 1, 0, 0, 0,  1,  5, 0, 0, 5, 0};
        vecs[1]  = '{0, 1, 0, 0, 0,  9,  5, 0, 0, 5, 0};
        vecs[2]  = '{0, 1, 0, 0, 0,  1,  4, 1, 0, 4, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 10,  3, 1, 0, 3, 0};
        vecs[4]  = '{0, 1, 0, 0, 0, 10,  2, 1, 0, 2, 0};
        vecs[5]  = '{0, 1, 0, 0, 0, 10,  1, 1, 0, 1, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 10,  0, 1, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 10,  5, 1, 1, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 0,  1,  5, 0, 0, 0, 1};
        vecs[9]  = '{0, 1, 1, 1, 0,  1,  0, 0, 0, 0, 0};
        vecs[10] = '{0, 1, 1, 0, 0, 10,  1, 1, 0, 1, 0};
        vecs[11] = '{0, 1, 1, 0, 0, 40,  5, 1, 0, 5, 0};
        vecs[12] = '{0, 1, 1, 0, 0, 10,  0, 1, 1, 5, 1};
        vecs[13] = '{0, 0, 1, 0, 0,  5,  0, 0, 0, 5, 1};
        vecs[14] = '{0, 1, 1, 0, 0, 15,  1, 0, 0, 5, 1};
        vecs[15] = '{0, 1, 0, 1, 9,  1,  5, 0, 0, 5, 0};
        vecs[16] = '{0, 1, 0, 0, 0,  9,  5, 0, 0, 5, 0};
        vecs[17] = '{0, 1, 0, 0, 0,  1,  4, 1, 0, 4, 0};
        vecs[18] = '{0, 1, 0, 0, 0,  6,  4, 0, 0, 4, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 20,  4, 0, 0, 4, 0};
        vecs[20] = '{0, 1, 0, 0, 0,  4,  4, 0, 0, 4, 0};
        vecs[21] = '{0, 1, 0, 0, 0,  1,  3, 1, 0, 3, 0};
        vecs[22] = '{0, 1, 0, 0, 0,  9,  3, 0, 0, 3, 0};
        vecs[23] = '{0, 1, 0, 1, 2,  1,  2, 0, 0, 2, 0};
        vecs[24] = '{0, 1, 0, 0, 0,  9,  2, 0, 0, 2, 0};
        vecs[25] = '{0, 1, 0, 0, 0,  1,  1, 1, 0, 1, 0};
        vecs[26] = '{0, 1, 0, 0, 0,  3,  1, 0, 0, 1, 0};
        vecs[27] = '{1, 0, 0, 0, 0,  1,  5, 0, 0, 5, 0};
        vecs[28] = '{0, 0, 0, 0, 0, 12,  5, 0, 0, 5, 0};

        reset = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0; load_val = 4'd0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 29; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(vecs[i].reset[0], vecs[i].en[0], vecs[i].dir[0],
                              vecs[i].load[0], 4'(vecs[i].lv));
                checkOutput();
            end
            check($sformatf("row%0d value_w", i), int'(value_w), vecs[i].wv);
            check($sformatf("row%0d hex_w", i),   int'(hex_w),   int'(seg_tab[vecs[i].wv]));
            check($sformatf("row%0d tick_w", i),  int'(tick_w),  vecs[i].tk);
            check($sformatf("row%0d done_w", i),  int'(done_w),  vecs[i].wd);
            check($sformatf("row%0d value_h", i), int'(value_h), vecs[i].hv);
            check($sformatf("row%0d tick_h", i),  int'(tick_h),  vecs[i].tk);
            check($sformatf("row%0d done_h", i),  int'(done_h),  vecs[i].hd);
        end

        $display("[TB] randomized run against reference model");
        r_dir = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(99) < 3) r_dir = ~r_dir;
            applyStimulus($urandom_range(999) < 3,
                          $urandom_range(99) < 90,
                          r_dir,
                          $urandom_range(999) < 12,
                          4'($urandom_range(15)));
            checkOutput();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
